// File: rtl/rs_pkg.sv
// Constants and types shared by the reservation station array and its issue-select logic.
package rs_pkg;
    localparam int NUM_RS_ENTRIES = 5;
    localparam int RS_IDX_W       = 5;
    localparam int RS_CNT_W       = 3;

    typedef enum logic {
        ISS_IDLE,
        ISS_PRESENT
    } issState_e;
endpackage

// File: rtl/rs_age_queue.sv
// Compacting age queue of RS entry indices, slot 0 oldest, with a per-slot issuing bit.
module rs_age_queue
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_RS_ENTRIES,
    parameter int IDX_W       = RS_IDX_W,
    parameter int CNT_W       = RS_CNT_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                pushValid,
    input  logic [IDX_W-1:0]                    pushIdx,
    input  logic                                removeIssuing,
    input  logic                                markValid,
    input  logic [CNT_W-1:0]                    markSlot,
    output logic [NUM_ENTRIES-1:0][IDX_W-1:0]   slotIdx,
    output logic [NUM_ENTRIES-1:0]              slotValid,
    output logic [NUM_ENTRIES-1:0]              slotIssuing,
    output logic [CNT_W-1:0]                    count,
    output logic                                full,
    output logic                                empty
);
    logic [CNT_W-1:0]                  remPos;
    logic                              removeHit;
    logic [CNT_W-1:0]                  countAfter;
    logic [NUM_ENTRIES:0][IDX_W-1:0]   extIdx;
    logic [NUM_ENTRIES:0]              extValid;
    logic [NUM_ENTRIES:0]              extIssuing;
    logic [NUM_ENTRIES-1:0][IDX_W-1:0] nextIdx;
    logic [NUM_ENTRIES-1:0]            nextValid;
    logic [NUM_ENTRIES-1:0]            nextIssuing;

    // Marking uses pre-compaction slot numbers, so apply it before the shift.
    always_comb begin
        remPos    = CNT_W'(NUM_ENTRIES);
        removeHit = 1'b0;
        for (int s = 0; s < NUM_ENTRIES; s++) begin
            if (removeIssuing && slotValid[s] && slotIssuing[s]) begin
                remPos    = CNT_W'(s);
                removeHit = 1'b1;
            end
        end
        extIdx     = {{IDX_W{1'b0}}, slotIdx};
        extValid   = {1'b0, slotValid};
        extIssuing = '0;
        for (int s = 0; s < NUM_ENTRIES; s++) begin
            extIssuing[s] = slotIssuing[s] | (markValid && markSlot == CNT_W'(s));
        end
        countAfter = count - CNT_W'(removeHit);
        for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (CNT_W'(j) >= remPos) begin
                nextIdx[j]     = extIdx[j+1];
                nextValid[j]   = extValid[j+1];
                nextIssuing[j] = extIssuing[j+1];
            end else begin
                nextIdx[j]     = extIdx[j];
                nextValid[j]   = extValid[j];
                nextIssuing[j] = extIssuing[j];
            end
            if (pushValid && countAfter == CNT_W'(j)) begin
                nextIdx[j]     = pushIdx;
                nextValid[j]   = 1'b1;
                nextIssuing[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slotValid   <= '0;
            slotIssuing <= '0;
            count       <= '0;
        end else if (flush) begin
            slotValid   <= '0;
            slotIssuing <= '0;
            count       <= '0;
        end else begin
            slotValid   <= nextValid;
            slotIssuing <= nextIssuing & nextValid;
            count       <= countAfter + CNT_W'(pushValid);
        end
    end

    // Index payload is qualified by slotValid and needs no reset.
    always_ff @(posedge clk) begin
        slotIdx <= nextIdx;
    end

    assign full  = (count == CNT_W'(NUM_ENTRIES));
    assign empty = (count == '0);
endmodule

// File: rtl/rs_issue_select.sv
// Picks the oldest operand-ready RS entry and presents it to ALU dispatch via valid/ready.
module rs_issue_select
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_RS_ENTRIES,
    parameter int IDX_W       = RS_IDX_W,
    parameter int CNT_W       = RS_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   alloc_valid,
    input  logic [IDX_W-1:0]       alloc_idx,
    input  logic [NUM_ENTRIES-1:0] rs_ready,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [IDX_W-1:0]       issue_idx,
    output logic [CNT_W-1:0]       queue_count,
    output logic                   queue_full,
    output logic                   queue_empty,
    output logic                   alloc_err
);
    issState_e                          state;
    logic [NUM_ENTRIES-1:0][IDX_W-1:0]  slotIdx;
    logic [NUM_ENTRIES-1:0]             slotValid;
    logic [NUM_ENTRIES-1:0]             slotIssuing;
    logic                               handshake;
    logic                               removeIssuing;
    logic                               markValid;
    logic                               candFound;
    logic [CNT_W-1:0]                   candSlot;
    logic [IDX_W-1:0]                   candIdx;
    logic                               dupHit;
    logic                               allocOk;
    logic                               pushValid;
    logic [CNT_W-1:0]                   countAfter;

    function automatic logic readyOf(input logic [NUM_ENTRIES-1:0] rdy, input logic [IDX_W-1:0] idx);
        logic r;
        r = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (idx == IDX_W'(e)) r = rdy[e];
        end
        return r;
    endfunction

    assign handshake     = (state == ISS_PRESENT) && issue_ready;
    assign removeIssuing = handshake && !flush;
    assign markValid     = candFound && !flush && ((state == ISS_IDLE) || handshake);

    // Scan youngest to oldest so the oldest qualifying slot wins.
    always_comb begin
        candFound = 1'b0;
        candSlot  = '0;
        candIdx   = '0;
        for (int s = NUM_ENTRIES - 1; s >= 0; s--) begin
            if (slotValid[s] && !slotIssuing[s] && readyOf(rs_ready, slotIdx[s])) begin
                candFound = 1'b1;
                candSlot  = CNT_W'(s);
                candIdx   = slotIdx[s];
            end
        end
    end

    // The slot leaving this cycle no longer counts as a duplicate or toward fullness.
    always_comb begin
        dupHit = 1'b0;
        for (int s = 0; s < NUM_ENTRIES; s++) begin
            if (slotValid[s] && slotIdx[s] == alloc_idx && !(removeIssuing && slotIssuing[s]))
                dupHit = 1'b1;
        end
        countAfter = queue_count - CNT_W'(removeIssuing);
        allocOk    = (alloc_idx < IDX_W'(NUM_ENTRIES)) && !dupHit
                     && (countAfter != CNT_W'(NUM_ENTRIES));
        pushValid  = alloc_valid && !flush && allocOk;
    end

    rs_age_queue #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W)
    ) ageQueue (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .pushValid    (pushValid),
        .pushIdx      (alloc_idx),
        .removeIssuing(removeIssuing),
        .markValid    (markValid),
        .markSlot     (candSlot),
        .slotIdx      (slotIdx),
        .slotValid    (slotValid),
        .slotIssuing  (slotIssuing),
        .count        (queue_count),
        .full         (queue_full),
        .empty        (queue_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ISS_IDLE;
            issue_idx <= '0;
            alloc_err <= 1'b0;
        end else begin
            if (alloc_valid && !flush && !allocOk) alloc_err <= 1'b1;
            if (flush) begin
                state <= ISS_IDLE;
            end else begin
                case (state)
                    ISS_IDLE: begin
                        if (candFound) begin
                            issue_idx <= candIdx;
                            state     <= ISS_PRESENT;
                        end
                    end
                    ISS_PRESENT: begin
                        if (issue_ready) begin
                            if (candFound) issue_idx <= candIdx;
                            else           state     <= ISS_IDLE;
                        end
                    end
                    default: state <= ISS_IDLE;
                endcase
            end
        end
    end

    assign issue_valid = (state == ISS_PRESENT);
endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select: ordering, hold, full/duplicate, flush and reset cases.
module tb_rs_issue_select;
    logic       clk;
    logic       reset;
    logic       flush;
    logic       alloc_valid;
    logic [4:0] alloc_idx;
    logic [4:0] rs_ready;
    logic       issue_valid;
    logic       issue_ready;
    logic [4:0] issue_idx;
    logic [2:0] queue_count;
    logic       queue_full;
    logic       queue_empty;
    logic       alloc_err;

    int nAssert = 0;
    int nFail   = 0;

    rs_issue_select dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .alloc_valid(alloc_valid),
        .alloc_idx  (alloc_idx),
        .rs_ready   (rs_ready),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_idx  (issue_idx),
        .queue_count(queue_count),
        .queue_full (queue_full),
        .queue_empty(queue_empty),
        .alloc_err  (alloc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        flush       = 1'b0;
        alloc_valid = 1'b0;
        alloc_idx   = '0;
        rs_ready    = '0;
        issue_ready = 1'b0;
        #12;
        chk("rst_valid", issue_valid, 0);
        chk("rst_idx", issue_idx, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_empty", queue_empty, 1);
        chk("rst_full", queue_full, 0);
        chk("rst_err", alloc_err, 0);
        #10 reset = 1'b1;
        tick();

        // In-order issue of 2, 0, 4 at one per clock
        rs_ready = 5'b10101; issue_ready = 1'b1;
        alloc_valid = 1'b1; alloc_idx = 5'd2; tick();
        chk("t1_count1", queue_count, 1);
        chk("t1_novalid", issue_valid, 0);
        alloc_idx = 5'd0; tick();
        chk("t1_v2", issue_valid, 1);
        chk("t1_idx2", issue_idx, 2);
        alloc_idx = 5'd4; tick();
        chk("t1_idx0", issue_idx, 0);
        chk("t1_count2", queue_count, 2);
        alloc_valid = 1'b0; tick();
        chk("t1_idx4", issue_idx, 4);
        chk("t1_count3", queue_count, 1);
        tick();
        chk("t1_idle", issue_valid, 0);
        chk("t1_count0", queue_count, 0);
        chk("t1_empty", queue_empty, 1);

        // Oldest-ready rule: 3 ready first, 1 later
        rs_ready = 5'b01000;
        alloc_valid = 1'b1; alloc_idx = 5'd1; tick();
        alloc_idx = 5'd3; tick();
        chk("t2_none", issue_valid, 0);
        alloc_valid = 1'b0; tick();
        chk("t2_v3", issue_valid, 1);
        chk("t2_idx3", issue_idx, 3);
        rs_ready = 5'b00010; tick();
        chk("t2_v1", issue_valid, 1);
        chk("t2_idx1", issue_idx, 1);
        tick();
        chk("t2_idle", issue_valid, 0);
        chk("t2_count0", queue_count, 0);

        // Back-pressure holds entry 2 stable
        rs_ready = 5'b00100; issue_ready = 1'b0;
        alloc_valid = 1'b1; alloc_idx = 5'd2; tick();
        alloc_valid = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_v", issue_valid, 1);
            chk("t3_hold_idx", issue_idx, 2);
            chk("t3_hold_cnt", queue_count, 1);
            tick();
        end
        issue_ready = 1'b1; tick();
        chk("t3_rel_v", issue_valid, 0);
        chk("t3_rel_cnt", queue_count, 0);
        tick();
        chk("t3_once_v", issue_valid, 0);
        chk("t3_once_cnt", queue_count, 0);

        // Full queue: issue 3 and re-allocate 3 in the same cycle
        rs_ready = 5'b00000;
        alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alloc_idx = 5'(i); tick();
        end
        chk("t4_cnt5", queue_count, 5);
        chk("t4_full", queue_full, 1);
        alloc_valid = 1'b0; rs_ready = 5'b01000; tick();
        chk("t4_v3", issue_valid, 1);
        chk("t4_idx3", issue_idx, 3);
        alloc_valid = 1'b1; alloc_idx = 5'd3; tick();
        chk("t4_cnt_keep", queue_count, 5);
        chk("t4_err0", alloc_err, 0);
        chk("t4_idle", issue_valid, 0);
        tick();
        chk("t4_dup_err", alloc_err, 1);
        chk("t4_dup_cnt", queue_count, 5);
        alloc_valid = 1'b0; tick();
        chk("t4_sticky", alloc_err, 1);
        chk("t4_cnt4", queue_count, 4);
        #2 reset = 1'b0;
        #1;
        chk("t4_rst_err", alloc_err, 0);
        chk("t4_rst_cnt", queue_count, 0);
        #2 reset = 1'b1;
        tick();

        // Flush during PRESENT overrides a same-cycle allocation
        rs_ready = 5'b00111; issue_ready = 1'b0;
        alloc_valid = 1'b1; alloc_idx = 5'd0; tick();
        alloc_idx = 5'd1; tick();
        alloc_idx = 5'd2; tick();
        chk("t5_v0", issue_valid, 1);
        chk("t5_cnt3", queue_count, 3);
        flush = 1'b1; alloc_idx = 5'd4; issue_ready = 1'b1; tick();
        chk("t5_fl_v", issue_valid, 0);
        chk("t5_fl_cnt", queue_count, 0);
        chk("t5_fl_empty", queue_empty, 1);
        chk("t5_fl_err", alloc_err, 0);
        flush = 1'b0; alloc_valid = 1'b0; tick();
        chk("t5_drop_cnt", queue_count, 0);
        chk("t5_drop_v", issue_valid, 0);

        // Out-of-range index, then async reset mid-PRESENT
        alloc_valid = 1'b1; alloc_idx = 5'd7; tick();
        chk("t6_err", alloc_err, 1);
        chk("t6_cnt", queue_count, 0);
        rs_ready = 5'b00001; issue_ready = 1'b0;
        alloc_idx = 5'd0; tick();
        alloc_valid = 1'b0; tick();
        chk("t6_v0", issue_valid, 1);
        reset = 1'b0;
        #1;
        chk("t6_async_v", issue_valid, 0);
        chk("t6_async_err", alloc_err, 0);
        tick();
        #2 reset = 1'b1;
        tick();
        chk("t6_empty", queue_empty, 1);
        chk("t6_post_v", issue_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule

// File: doc/rs_issue_select.md
Name: rs_issue_select

Overview:
- Issue-select stage directly downstream of the 5-entry reservation station array.
- Tracks allocation order of occupied RS entries and, each cycle, picks the oldest entry whose operands are both valid.
- Presents the picked entry's index to the ALU dispatch path with a valid/ready handshake; the RS array reads that index on the following clock.
- Supports a flush from branch recovery.

Parameters:
- NUM_ENTRIES, 5, number of reservation station entries tracked.
- IDX_W, 5, width of entry index (matches RS index port).
- CNT_W, 3, width of occupancy count; must hold 0..NUM_ENTRIES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of age queue and pending issue (branch mispredict).
- alloc_valid  input  1  an RS entry was written this cycle.
- alloc_idx  input  IDX_W  index of the entry written.
- rs_ready  input  NUM_ENTRIES  per-entry operands-valid vector from the RS array (bit i = entry i).
- issue_valid  output  1  issue_idx holds a selected entry.
- issue_ready  input  1  ALU dispatch accepts the presented entry.
- issue_idx  output  IDX_W  selected RS entry index.
- queue_count  output  CNT_W  number of entries in the age queue.
- queue_full  output  1  queue_count == NUM_ENTRIES.
- queue_empty  output  1  queue_count == 0.
- alloc_err  output  1  sticky flag for an illegal allocation.

Behaviour:
- Reset (reset low, async):
  - queue emptied; queue_count = 0; queue_empty = 1; queue_full = 0.
  - issue_valid = 0; issue_idx = 0; alloc_err = 0.
- Age queue: ordered list, slot 0 = oldest. Each slot holds an index plus a per-slot "issuing" bit. Compacting shift queue: removal shifts younger slots toward slot 0.
- Allocation: on alloc_valid, alloc_idx is appended at the tail. It is ignored and alloc_err is set (sticky until reset) when:
  - alloc_idx >= NUM_ENTRIES;
  - alloc_idx is already present in the queue;
  - the queue is full after this cycle's removal.
- Selection (combinational): the candidate is the lowest slot whose index has rs_ready set and whose issuing bit is clear.
- Issue register: FSM with two states.
  - IDLE (issue_valid = 0): if a candidate exists, load issue_idx, set that slot's issuing bit, go to PRESENT next cycle. Latency: ready entry to issue_valid = 1 clock.
  - PRESENT (issue_valid = 1):
    - issue_idx stays stable while issue_ready = 0.
    - On issue_valid && issue_ready: remove the issuing slot from the queue. If another candidate exists (the issued entry excluded), load it the same edge and stay in PRESENT, giving back-to-back issue at 1 per clock. Otherwise go to IDLE.
- Simultaneous remove and alloc: compaction first, then the append goes to the new tail. A full queue that issues and allocates in the same cycle accepts the allocation.
- An entry allocated in cycle N is selectable from cycle N+1; it may issue in N+1 and appear on issue_valid at N+2.
- rs_ready dropping for the entry currently presented does not retract issue; that is the RS array's responsibility.
- flush:
  - Queue cleared, issue_valid = 0, FSM to IDLE next edge.
  - Overrides alloc_valid and the handshake in the same cycle; alloc_err is unaffected.
- Reset asserted mid-handshake: issue_valid drops immediately (async); no removal is recorded.

Decomposition:
- Shared package rs_pkg: NUM_RS_ENTRIES, RS_IDX_W, RS_CNT_W constants, plus an issue-state enum {ISS_IDLE, ISS_PRESENT}. The ReservationStations array uses the same constants.
- Sub-module rs_age_queue: compacting queue with push, remove-at-slot, flush, per-slot issuing bit, and count/full/empty outputs.
- rs_issue_select: holds the priority pick and handshake FSM.

Test Plan:
- Reset, then alloc 2, 0, 4 on consecutive cycles; rs_ready = 5'b10101 from the start; issue_ready = 1 -> issue_idx sequence 2, 0, 4 on consecutive cycles; queue_count returns to 0.
- Alloc 1 then 3; rs_ready = 5'b01000 only -> issue_idx = 3 first; set bit1 later -> issue_idx = 1; oldest-ready rule respected.
- Issue entry 2 with issue_ready = 0 for 4 cycles -> issue_valid = 1 and issue_idx = 2 held stable; entry 2 is not re-selected; release -> removed exactly once.
- Fill all 5; same cycle issue_valid && issue_ready and alloc_idx = 3 (the issued index) -> allocation accepted, queue_count stays 5, alloc_err = 0. Alloc 3 again while it is queued -> alloc_err = 1 and sticky.
- Alloc 0, 1, 2 with ready set, then flush during PRESENT with alloc_valid = 1 (idx 4) -> next cycle issue_valid = 0, queue_count = 0, alloc of 4 dropped.
- Alloc_idx = 7 -> ignored, alloc_err = 1; reset low mid-PRESENT -> issue_valid = 0 immediately; after release queue_empty = 1.
